// File: rtl/switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : switch_conditioner
// Purpose  : Synchronises, debounces and holds one raw push-button level, and
//            emits one-cycle press, release and long-press strobes. Defining
//            SWITCH_COND_REPEAT_EN adds a periodic repeat strobe while the
//            button stays held after a long press.
// Revision : 1.0  initial release
// ============================================================================
module switch_conditioner #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int HOLD_LIMIT     = 25000000,
    parameter int REPEAT_PERIOD  = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long_Press,
    output logic o_Repeat
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_LIMIT) + 1;
    localparam int c_HOLD_W = $clog2(HOLD_LIMIT) + 1;

    // Debounce counter saturates at LIMIT-1; the level is accepted on the
    // cycle the counter would step from LIMIT-2 to LIMIT-1.
    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [c_DB_W-1:0]   c_DB_PRE   = c_DB_W'(DEBOUNCE_LIMIT - 2);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(HOLD_LIMIT);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PRE = c_HOLD_W'(HOLD_LIMIT - 1);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    state_t              r_state;
    state_t              w_state_next;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_DB_W-1:0]   w_db_cnt_next;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_next;
    logic                w_press_next;
    logic                w_release_next;
    logic                w_long_next;
    logic                w_held_now;
    logic                w_held_next;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM next-state, debounce counter and press/release decode.
    always_comb begin
        w_state_next   = r_state;
        w_db_cnt_next  = r_db_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        case (r_state)
            S_LOW: begin
                if (r_sync2) begin
                    w_db_cnt_next = '0;
                    w_state_next  = S_RISE;
                end
            end
            S_RISE: begin
                if (!r_sync2) begin
                    w_state_next = S_LOW;
                end else begin
                    if (r_db_cnt != c_DB_LAST) w_db_cnt_next = r_db_cnt + 1'b1;
                    if (r_db_cnt == c_DB_PRE) begin
                        w_state_next = S_HIGH;
                        w_press_next = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (!r_sync2) begin
                    w_db_cnt_next = '0;
                    w_state_next  = S_FALL;
                end
            end
            S_FALL: begin
                if (r_sync2) begin
                    w_state_next = S_HIGH;
                end else begin
                    if (r_db_cnt != c_DB_LAST) w_db_cnt_next = r_db_cnt + 1'b1;
                    if (r_db_cnt == c_DB_PRE) begin
                        w_state_next   = S_LOW;
                        w_release_next = 1'b1;
                    end
                end
            end
            default: w_state_next = S_LOW;
        endcase
    end

    // Hold counter only advances while the press persists into the next
    // cycle, so the long-press strobe can never collide with a release.
    always_comb begin
        w_held_now      = (r_state == S_HIGH) || (r_state == S_FALL);
        w_held_next     = (w_state_next == S_HIGH) || (w_state_next == S_FALL);
        w_hold_cnt_next = r_hold_cnt;
        w_long_next     = 1'b0;
        if (w_press_next) begin
            w_hold_cnt_next = '0;
        end else if (w_held_now && w_held_next) begin
            if (r_hold_cnt != c_HOLD_MAX) w_hold_cnt_next = r_hold_cnt + 1'b1;
            w_long_next = (r_hold_cnt == c_HOLD_PRE);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state      <= S_LOW;
            r_db_cnt     <= '0;
            r_hold_cnt   <= '0;
            o_Switch     <= 1'b0;
            o_Press      <= 1'b0;
            o_Release    <= 1'b0;
            o_Long_Press <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_db_cnt     <= w_db_cnt_next;
            r_hold_cnt   <= w_hold_cnt_next;
            o_Switch     <= w_held_next;
            o_Press      <= w_press_next;
            o_Release    <= w_release_next;
            o_Long_Press <= w_long_next;
        end
    end

`ifdef SWITCH_COND_REPEAT_EN
    localparam int c_REP_W = $clog2(REPEAT_PERIOD) + 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_PERIOD - 1);

    logic               r_rep_active;
    logic               w_rep_active_next;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_REP_W-1:0] w_rep_cnt_next;
    logic               w_repeat_next;

    // Repeat timer armed by the long press, running while the press lasts.
    always_comb begin
        w_rep_active_next = r_rep_active;
        w_rep_cnt_next    = r_rep_cnt;
        w_repeat_next     = 1'b0;
        if (!w_held_next) begin
            w_rep_active_next = 1'b0;
            w_rep_cnt_next    = '0;
        end else if (w_long_next) begin
            w_rep_active_next = 1'b1;
            w_rep_cnt_next    = '0;
        end else if (r_rep_active) begin
            if (r_rep_cnt == c_REP_LAST) begin
                w_repeat_next  = 1'b1;
                w_rep_cnt_next = '0;
            end else begin
                w_rep_cnt_next = r_rep_cnt + 1'b1;
            end
        end
    end

    // Repeat timer registers and strobe.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_rep_active <= 1'b0;
            r_rep_cnt    <= '0;
            o_Repeat     <= 1'b0;
        end else begin
            r_rep_active <= w_rep_active_next;
            r_rep_cnt    <= w_rep_cnt_next;
            o_Repeat     <= w_repeat_next;
        end
    end
`else
    // Without the repeat timer the strobe is tied low for any period value.
    localparam logic c_REPEAT_OFF = (REPEAT_PERIOD > 0) ? 1'b0 : 1'b0;
    assign o_Repeat = c_REPEAT_OFF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_conditioner
// Purpose  : Directed self-checking bench for switch_conditioner with
//            DEBOUNCE_LIMIT=8, HOLD_LIMIT=40, REPEAT_PERIOD=10. Expected
//            repeat strobes follow SWITCH_COND_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_switch_conditioner;

`ifdef SWITCH_COND_REPEAT_EN
    localparam logic REP = 1'b1;
`else
    localparam logic REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sw_in;
    logic o_Switch, o_Press, o_Release, o_Long_Press, o_Repeat;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    switch_conditioner #(
        .DEBOUNCE_LIMIT (8),
        .HOLD_LIMIT     (40),
        .REPEAT_PERIOD  (10)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Switch     (sw_in),
        .o_Switch     (o_Switch),
        .o_Press      (o_Press),
        .o_Release    (o_Release),
        .o_Long_Press (o_Long_Press),
        .o_Repeat     (o_Repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Vector order: {switch, press, release, long_press, repeat}
    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {o_Switch, o_Press, o_Release, o_Long_Press, o_Repeat};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic step_check(input string tag, input logic [4:0] exp);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    task automatic idle(input string tag, input int n, input logic [4:0] exp);
        for (int i = 0; i < n; i++) step_check(tag, exp);
    endtask

    initial begin
        rst   = 1'b1;
        sw_in = 1'b0;
        idle("reset_state", 2, 5'b00000);
        #2 rst = 1'b0;

        // Clean press: pin sampled high from edge 10, press at edge 19.
        idle("idle_low", 9, 5'b00000);
        sw_in = 1'b1;
        idle("press_wait", 9, 5'b00000);
        step_check("press", 5'b11000);

        // Long press 40 cycles after press, then repeats every 10.
        idle("hold", 39, 5'b10000);
        step_check("long_press", 5'b10010);
        for (int r = 0; r < 3; r++) begin
            idle("repeat_gap", 9, 5'b10000);
            step_check("repeat", {4'b1000, REP});
        end

        // Release with bounce: 0 x5, 1 x2, then 0 from edge 97.
        sw_in = 1'b0;
        idle("fall_bounce", 5, 5'b10000);
        sw_in = 1'b1;
        idle("fall_bounce", 2, 5'b10000);
        sw_in = 1'b0;
        idle("fall_settle", 2, 5'b10000);
        step_check("fall_repeat", {4'b1000, REP});
        idle("fall_settle", 6, 5'b10000);
        step_check("release", 5'b00100);
        idle("low_after", 5, 5'b00000);

        // Bounce reject: 1,0,1,0 every 3 cycles, then low.
        for (int b = 0; b < 2; b++) begin
            sw_in = 1'b1;
            idle("bounce", 3, 5'b00000);
            sw_in = 1'b0;
            idle("bounce", 3, 5'b00000);
        end
        idle("bounce_settle", 12, 5'b00000);

        // Reset mid-hold.
        sw_in = 1'b1;
        idle("press2_wait", 9, 5'b00000);
        step_check("press2", 5'b11000);
        idle("hold2", 5, 5'b10000);
        #2 rst = 1'b1;
        #1 check("reset_mid_hold", 5'b00000);
        idle("reset_held", 2, 5'b00000);
        rst = 1'b0;
        idle("rearm_wait", 9, 5'b00000);
        step_check("press_after_reset", 5'b11000);
        idle("hold3", 3, 5'b10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
